// File: rtl/dmem_port_arbiter_if.sv
// Bundles the CPU, VGA, buffer-control and shared DMEM signals of the arbiter.
interface dmem_port_arbiter_if #(
    parameter int unsigned ADDR_W = 12
);
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [31:0]       cpu_wdata;
    logic [3:0]        cpu_be;
    logic              cpu_gnt;
    logic              cpu_rvalid;
    logic [31:0]       cpu_rdata;

    logic              vga_req;
    logic [ADDR_W-1:0] vga_addr;
    logic              vga_frame_end;
    logic              vga_gnt;
    logic              vga_rvalid;
    logic [31:0]       vga_rdata;

    logic              swap_req;
    logic              swap_pending;
    logic              disp_buf;

    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [3:0]        mem_be;
    logic              mem_wr_en;
    logic              mem_rd_en;
    logic [31:0]       mem_rdata;

    // Arbiter side.
    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_be,
        output cpu_gnt, cpu_rvalid, cpu_rdata,
        input  vga_req, vga_addr, vga_frame_end,
        output vga_gnt, vga_rvalid, vga_rdata,
        input  swap_req,
        output swap_pending, disp_buf,
        output mem_addr, mem_wdata, mem_be, mem_wr_en, mem_rd_en,
        input  mem_rdata
    );

    // Requester / memory side.
    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_be,
        input  cpu_gnt, cpu_rvalid, cpu_rdata,
        output vga_req, vga_addr, vga_frame_end,
        input  vga_gnt, vga_rvalid, vga_rdata,
        output swap_req,
        input  swap_pending, disp_buf,
        input  mem_addr, mem_wdata, mem_be, mem_wr_en, mem_rd_en,
        output mem_rdata
    );
endinterface

// File: rtl/dmem_port_arbiter.sv
// Shares one synchronous-read DMEM port between the CPU and VGA scanout,
// with a starvation override for VGA and double-buffered frame selection.
module dmem_port_arbiter #(
    parameter int unsigned ADDR_W      = 12,
    parameter int unsigned MAX_WAIT    = 8,
    parameter int unsigned FRAME_WORDS = 1200
) (
    input  logic                clk,
    input  logic                rst,
    dmem_port_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CPU_RD = 2'd1,
        VGA_RD = 2'd2
    } state_t;

    localparam logic [3:0]        WAIT_LIMIT = 4'(MAX_WAIT);
    localparam logic [ADDR_W-1:0] FRAME_OFS  = ADDR_W'(FRAME_WORDS);

    state_t      state;
    logic [3:0]  wait_cnt;
    logic        disp_buf_q;
    logic        swap_pending_q;
    logic        cpu_gnt_c;
    logic        vga_gnt_c;

    // Grant decision: CPU has priority unless VGA has waited MAX_WAIT cycles.
    always_comb begin
        cpu_gnt_c = 1'b0;
        vga_gnt_c = 1'b0;
        if (rst) begin
            vga_gnt_c = bus.vga_req && (!bus.cpu_req || (wait_cnt == WAIT_LIMIT));
            cpu_gnt_c = bus.cpu_req && !vga_gnt_c;
        end
    end

    // Steer the granted requester onto the shared DMEM port.
    always_comb begin
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        bus.mem_be    = '0;
        bus.mem_wr_en = 1'b0;
        bus.mem_rd_en = 1'b0;
        if (cpu_gnt_c) begin
            bus.mem_addr  = bus.cpu_addr;
            bus.mem_wdata = bus.cpu_wdata;
            bus.mem_be    = bus.cpu_be;
            bus.mem_wr_en = bus.cpu_we;
            bus.mem_rd_en = !bus.cpu_we;
        end else if (vga_gnt_c) begin
            bus.mem_addr  = bus.vga_addr + (disp_buf_q ? FRAME_OFS : '0);
            bus.mem_be    = 4'hF;
            bus.mem_rd_en = 1'b1;
        end
    end

    // Grants and read returns; rdata is only meaningful alongside its rvalid.
    always_comb begin
        bus.cpu_gnt      = cpu_gnt_c;
        bus.vga_gnt      = vga_gnt_c;
        bus.cpu_rvalid   = (state == CPU_RD);
        bus.vga_rvalid   = (state == VGA_RD);
        bus.cpu_rdata    = (state == CPU_RD) ? bus.mem_rdata : '0;
        bus.vga_rdata    = (state == VGA_RD) ? bus.mem_rdata : '0;
        bus.swap_pending = swap_pending_q;
        bus.disp_buf     = disp_buf_q;
    end

    // Remember who owns the read data returning next cycle, and VGA wait time.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            wait_cnt <= '0;
        end else begin
            if (cpu_gnt_c && !bus.cpu_we) begin
                state <= CPU_RD;
            end else if (vga_gnt_c) begin
                state <= VGA_RD;
            end else begin
                state <= IDLE;
            end

            if (bus.vga_req && !vga_gnt_c) begin
                wait_cnt <= (wait_cnt >= WAIT_LIMIT) ? WAIT_LIMIT : wait_cnt + 4'd1;
            end else begin
                wait_cnt <= '0;
            end
        end
    end

    // Double-buffer swap: arm on request, flip the display buffer at frame end.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            disp_buf_q     <= 1'b0;
            swap_pending_q <= 1'b0;
        end else if (bus.vga_frame_end && swap_pending_q) begin
            disp_buf_q     <= !disp_buf_q;
            swap_pending_q <= 1'b0;
        end else if (bus.swap_req) begin
            swap_pending_q <= 1'b1;
        end
    end
endmodule

// File: doc/dmem_port_arbiter.md
DMEM_PORT_ARBITER -- requirements
Module: dmem_port_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 12, DMEM word-address width.
REQ-002 SHALL have parameter MAX_WAIT, default 8, VGA starvation limit in cycles (1..15).
REQ-003 SHALL have parameter FRAME_WORDS, default 1200, words per frame buffer.
REQ-004 SHALL have port clk  in  1  clock.
REQ-005 SHALL have port rst  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have ports cpu_req in 1, cpu_we in 1, cpu_addr in ADDR_W, cpu_wdata in 32, cpu_be in 4: CPU access request.
REQ-007 SHALL have ports cpu_gnt out 1, cpu_rvalid out 1, cpu_rdata out 32: CPU grant and read return.
REQ-008 SHALL have ports vga_req in 1, vga_addr in ADDR_W (frame-relative word), vga_frame_end in 1: scanout read request and end-of-frame pulse.
REQ-009 SHALL have ports vga_gnt out 1, vga_rvalid out 1, vga_rdata out 32: VGA grant and read return.
REQ-010 SHALL have ports swap_req in 1 (pulse), swap_pending out 1, disp_buf out 1: double-buffer control and status.
REQ-011 SHALL have ports mem_addr out ADDR_W, mem_wdata out 32, mem_be out 4, mem_wr_en out 1, mem_rd_en out 1, mem_rdata in 32: shared DMEM port, synchronous read, 1-cycle latency.

Function
REQ-012 SHALL grant at most one requester per cycle; grant combinational in the request cycle.
REQ-013 SHALL grant CPU when cpu_req=1, unless starvation override (REQ-015) is active.
REQ-014 SHALL grant VGA when vga_req=1 and CPU not granted.
REQ-015 SHALL keep 4-bit wait_cnt: +1 each cycle vga_req=1 and vga_gnt=0, saturating at MAX_WAIT; cleared on vga_gnt=1 or vga_req=0; when wait_cnt==MAX_WAIT, VGA wins over CPU.
REQ-016 SHALL, for CPU grant, drive mem_addr=cpu_addr, mem_wdata=cpu_wdata, mem_be=cpu_be, mem_wr_en=cpu_we, mem_rd_en=!cpu_we.
REQ-017 SHALL, for VGA grant, drive mem_addr=(vga_addr + disp_buf*FRAME_WORDS) truncated to ADDR_W, mem_rd_en=1, mem_wr_en=0, mem_be=4'hF, mem_wdata=0.
REQ-018 SHALL drive mem_rd_en=0, mem_wr_en=0, mem_addr=0, mem_be=0 when no grant.
REQ-019 SHALL track last-cycle owner in state register {IDLE, CPU_RD, VGA_RD}: next = CPU_RD on CPU read grant, VGA_RD on VGA grant, IDLE otherwise (including CPU write).
REQ-020 SHALL assert cpu_rvalid exactly when state==CPU_RD, vga_rvalid exactly when state==VGA_RD; both rdata outputs = mem_rdata (qualified by rvalid).
REQ-021 SHALL set swap_pending on swap_req=1; on vga_frame_end=1 with swap_pending=1 (registered value), toggle disp_buf and clear swap_pending.
REQ-022 SHALL, on swap_req and vga_frame_end same cycle with swap_pending=0, set swap_pending and not toggle disp_buf until the next vga_frame_end.
REQ-023 SHALL ignore swap_req while swap_pending=1 (no double toggle).
REQ-024 SHALL apply disp_buf change to VGA addressing from the cycle after the toggle; a VGA grant in the toggle cycle uses the old buffer.

Reset
REQ-025 SHALL, while rst=0, force state=IDLE, wait_cnt=0, disp_buf=0, swap_pending=0, cpu_rvalid=0, vga_rvalid=0, grants=0, mem_rd_en=0, mem_wr_en=0.
REQ-026 SHALL discard any in-flight read on reset; no rvalid in the first cycle after rst deasserts.

Verification
REQ-027 SHALL test: cpu_req and vga_req both held constantly, MAX_WAIT=8 -> CPU granted 8 cycles, VGA granted cycle 9, pattern repeats.
REQ-028 SHALL test: CPU read addr 5, mem_rdata=32'hDEADBEEF next cycle -> cpu_rvalid=1, cpu_rdata=DEADBEEF, vga_rvalid=0.
REQ-029 SHALL test: disp_buf=1, vga_addr=10, FRAME_WORDS=1200 -> mem_addr=1210, mem_rd_en=1.
REQ-030 SHALL test: swap_req pulse, then vga_frame_end 50 cycles later -> swap_pending=1 for those cycles, disp_buf 0->1 after frame_end, swap_pending=0.
REQ-031 SHALL test: swap_req coincident with vga_frame_end -> disp_buf unchanged, toggles at following frame_end.
REQ-032 SHALL test: rst asserted the cycle after a VGA grant -> vga_rvalid stays 0, all outputs at reset values.
